// File: rtl/req_arbiter_8_pkg.sv
// rtl/req_arbiter_8_pkg.sv - shared types, sizes and round-robin pick helper for req_arbiter_8
// Contents: N_REQ/ID_W sizes, arb_state_t FSM states, pick_t result, rr_pick().
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] idx;
    } pick_t;

    // First set request at or after ptr, wrapping past N_REQ-1 back to 0.
    // The ID_W-bit add wraps naturally, which is exactly the rotation we want.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [ID_W-1:0]  ptr);
        pick_t           p;
        logic [ID_W-1:0] idx;
        p.found = 1'b0;
        p.idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + ID_W'(k);
            if (!p.found && req[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/req_arbiter_8_if.sv
// rtl/req_arbiter_8_if.sv - requester/arbiter handshake bundle
// Signals: en, req[7:0] (requester side drives); gnt[7:0], gnt_vld, gnt_id[2:0], preempt (arbiter drives).
// Modports: master = requester side, slave = arbiter side.
interface req_arbiter_8_if;
    import arb_pkg::*;

    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             gnt_vld;
    logic [ID_W-1:0]  gnt_id;
    logic             preempt;

    modport master (
        output en, req,
        input  gnt, gnt_vld, gnt_id, preempt
    );

    modport slave (
        input  en, req,
        output gnt, gnt_vld, gnt_id, preempt
    );

endinterface

// File: rtl/req_arbiter_8_decoder_3x8.sv
// rtl/req_arbiter_8_decoder_3x8.sv - 3-to-8 one-hot decoder with enable
// Ports: i_in[2:0] index, i_en enable, o_out[7:0] one-hot result (all zero when i_en=0).
module decoder_3x8 (
    input  logic [2:0] i_in,
    input  logic       i_en,
    output logic [7:0] o_out
);

    assign o_out = i_en ? (8'h01 << i_in) : 8'h00;

endmodule

// File: rtl/req_arbiter_8.sv
// rtl/req_arbiter_8.sv - 8-way round-robin arbiter with one-hot grant and hold-time limit
// Ports: clk, rst_n (async, active low); bus (slave modport): en, req[7:0] in;
//        gnt[7:0], gnt_vld, gnt_id[2:0], preempt out. MAX_HOLD=0 disables the hold limit.
module req_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    req_arbiter_8_if.slave bus
);

    // Kept at least 1 bit wide so MAX_HOLD=0 still elaborates.
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit HOLD_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EN ? MAX_HOLD - 1 : 0);

    arb_state_t       r_state, w_state_nxt;
    logic [ID_W-1:0]  r_ptr, w_ptr_nxt;
    logic [ID_W-1:0]  r_gnt_id, w_gnt_id_nxt;
    logic             r_gnt_vld, w_gnt_vld_nxt;
    logic             r_preempt, w_preempt_nxt;
    logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;

    pick_t            w_pick;
    logic [N_REQ-1:0] w_gnt;
    logic             w_others;

    // gnt is decoded purely from registers, so req never reaches gnt combinationally.
    decoder_3x8 u_dec (
        .i_in  (r_gnt_id),
        .i_en  (r_gnt_vld),
        .o_out (w_gnt)
    );

    assign bus.gnt     = w_gnt;
    assign bus.gnt_vld = r_gnt_vld;
    assign bus.gnt_id  = r_gnt_id;
    assign bus.preempt = r_preempt;

    always_comb begin
        w_pick        = rr_pick(bus.req, r_ptr);
        // In GRANT, w_gnt is exactly onehot(gnt_id), so this masks out the owner.
        w_others      = |(bus.req & ~w_gnt);

        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gnt_id_nxt  = r_gnt_id;
        w_gnt_vld_nxt = r_gnt_vld;
        w_hold_nxt    = r_hold_cnt;
        w_preempt_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                w_gnt_vld_nxt = 1'b0;
                if (bus.en && w_pick.found) begin
                    w_gnt_id_nxt  = w_pick.idx;
                    w_gnt_vld_nxt = 1'b1;
                    w_hold_nxt    = '0;
                    w_ptr_nxt     = w_pick.idx + 3'd1;
                    w_state_nxt   = GRANT;
                end
            end
            GRANT: begin
                if (!bus.en || !bus.req[r_gnt_id]) begin
                    // Release is checked before the limit so it never raises preempt.
                    w_gnt_vld_nxt = 1'b0;
                    w_state_nxt   = IDLE;
                end else if (HOLD_EN && (r_hold_cnt == HOLD_LAST) && w_others) begin
                    w_gnt_vld_nxt = 1'b0;
                    w_preempt_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end else if (r_hold_cnt != HOLD_LAST) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_gnt_vld_nxt = 1'b0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_gnt_id   <= '0;
            r_gnt_vld  <= 1'b0;
            r_hold_cnt <= '0;
            r_preempt  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_gnt_vld  <= w_gnt_vld_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_preempt  <= w_preempt_nxt;
        end
    end

endmodule
